// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scanner for an 8-bit 4:1 channel mux.
// It steps sel over the enabled channels and waits DWELL cycles on each one
// so the mux path can settle. It then captures the mux output and offers the
// byte plus its channel id downstream on a valid/ready handshake.
// Optional feature: define MUX_SCAN_CHANGE_EN to suppress captures whose
// value matches the last value presented for that channel.
module mux_scan_ctrl #(
  parameter int DW    = 8,
  parameter int DWELL = 4   // legal range 1..255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    chMask,
  input  logic [DW-1:0] muxIn,
  output logic [1:0]    sel,
  output logic [DW-1:0] dataOut,
  output logic [1:0]    chOut,
  output logic          valid,
  input  logic          ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  // First enabled channel at or after 'from', wrapping 3 -> 0.
  function automatic logic [1:0] next_ch(input logic [1:0] from,
                                         input logic [3:0] mask);
    logic [1:0] idx;
    // NOTE: assign the result and temporaries before any conditional path so
    // no path leaves them unassigned (which would infer a latch in comb logic).
    next_ch = from;
    idx     = from;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int k = 3; k >= 0; k--) begin
      idx = from + 2'(k);
      if (mask[idx]) next_ch = idx;
    end
  endfunction

  // Advancing after a transfer (or a suppressed capture) resumes the search
  // just past the channel that was served.
  logic [1:0] adv_ptr;
  logic [1:0] adv_sel;
  logic       adv_go;
  logic [1:0] idle_sel;

  assign adv_ptr  = sel + 2'd1;
  assign adv_sel  = next_ch(adv_ptr, chMask);
  assign adv_go   = en && (chMask != 4'b0000);
  assign idle_sel = next_ch(ptr, chMask);

  // A capture is skipped when it would repeat the last presented value.
  logic skip;

`ifdef MUX_SCAN_CHANGE_EN
  logic [DW-1:0] last [4];
  logic [3:0]    seen;

  assign skip = seen[sel] && (muxIn == last[sel]);

  // Remember the last presented value per channel.
  always_ff @(posedge clk) begin
    // NOTE: this small history array is cleared on reset because 'seen' must
    // start empty; large data memories normally have no reset.
    if (rst) begin
      seen <= 4'b0000;
      for (int i = 0; i < 4; i++) last[i] <= '0;
    end else if (state == SETTLE && cnt == 8'd0 && !skip) begin
      seen[sel] <= 1'b1;
      last[sel] <= muxIn;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // Scan state machine with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would create ordering-dependent logic.
    if (rst) begin
      state   <= IDLE;
      sel     <= 2'd0;
      dataOut <= '0;
      chOut   <= 2'd0;
      valid   <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (adv_go) begin
            sel   <= idle_sel;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (skip) begin
            ptr <= adv_ptr;
            if (adv_go) begin
              sel   <= adv_sel;
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end else begin
            dataOut <= muxIn;
            chOut   <= sel;
            valid   <= 1'b1;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            ptr   <= adv_ptr;
            if (adv_go) begin
              sel   <= adv_sel;
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl with a transaction-level
// reference model and a per-cycle output comparison.
// Define MUX_SCAN_CHANGE_EN when compiling to exercise the repeat-suppression
// feature.
module tb_mux_scan_ctrl;

  localparam int DW    = 8;
  localparam int DWELL = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [3:0]    chMask;
  logic [DW-1:0] muxIn;
  logic [1:0]    sel;
  logic [DW-1:0] dataOut;
  logic [1:0]    chOut;
  logic          valid;
  logic          ready;

  // Values presented on the four mux inputs; the mux itself is modelled here.
  logic [DW-1:0] chan_val [4];
  assign muxIn = chan_val[sel];

  mux_scan_ctrl #(.DW(DW), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .chMask  (chMask),
    .muxIn   (muxIn),
    .sel     (sel),
    .dataOut (dataOut),
    .chOut   (chOut),
    .valid   (valid),
    .ready   (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: tracks which channel is being scanned, the cycle on
  // which its capture is due, and the presented sample.
  // ---------------------------------------------------------------------
  int unsigned   cyc = 0;
  logic [1:0]    m_sel, m_ch, m_ptr;
  logic [DW-1:0] m_data;
  logic          m_valid, m_busy;
  int unsigned   m_due;
  logic [DW-1:0] m_last [4];
  logic [3:0]    m_seen;

  function automatic logic [1:0] first_enabled(input logic [1:0] from,
                                               input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (mask[(int'(from) + k) % 4]) return 2'((int'(from) + k) % 4);
    return from;
  endfunction

  task automatic m_try_start();
    if (en && chMask != 4'b0000) begin
      m_sel  = first_enabled(m_ptr, chMask);
      m_due  = cyc + DWELL;
      m_busy = 1'b1;
    end
  endtask

  task automatic m_capture();
    logic [DW-1:0] v;
    v      = chan_val[m_sel];
    m_busy = 1'b0;
`ifdef MUX_SCAN_CHANGE_EN
    if (m_seen[m_sel] && m_last[m_sel] == v) begin
      m_ptr = m_sel + 2'd1;
      m_try_start();
      return;
    end
    m_seen[m_sel] = 1'b1;
    m_last[m_sel] = v;
`endif
    m_data  = v;
    m_ch    = m_sel;
    m_valid = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_sel = 2'd0; m_ch = 2'd0; m_ptr = 2'd0; m_data = '0;
        m_valid = 1'b0; m_busy = 1'b0; m_due = 0; m_seen = 4'b0000;
        for (int i = 0; i < 4; i++) m_last[i] = '0;
      end else if (m_valid) begin
        if (ready) begin
          m_valid = 1'b0;
          m_ptr   = m_sel + 2'd1;
          m_try_start();
        end
      end else if (m_busy) begin
        if (cyc == m_due) m_capture();
      end else begin
        m_try_start();
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("sel",     32'(sel),     32'(m_sel));
      check("valid",   32'(valid),   32'(m_valid));
      check("dataOut", 32'(dataOut), 32'(m_data));
      check("chOut",   32'(chOut),   32'(m_ch));
    end
  end

  // Bounded wait for valid, sampled on falling edges.
  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  // Wait for a sequence of captures, checking channel, data and spacing.
  task automatic expect_seq(input string name, input int n,
                            input logic [1:0] chs [8], input logic [7:0] dats [8]);
    int unsigned last_cyc;
    last_cyc = 0;
    for (int k = 0; k < n; k++) begin
      wait_valid(name);
      check({name, "_ch"},   32'(chOut),   32'(chs[k]));
      check({name, "_sel"},  32'(sel),     32'(chs[k]));
      check({name, "_data"}, 32'(dataOut), 32'(dats[k]));
      if (k > 0) check({name, "_spacing"}, cyc - last_cyc, DWELL + 1);
      last_cyc = cyc;
    end
  endtask

  // Directed stimulus; inputs change on falling edges.
  initial begin
    logic [1:0] chs  [8];
    logic [7:0] dats [8];
    int         nv;

    rst = 1'b1; en = 1'b0; ready = 1'b0; chMask = 4'b0000;
    chan_val[0] = 8'h11; chan_val[1] = 8'h22;
    chan_val[2] = 8'h33; chan_val[3] = 8'h44;

    // 1: reset values, and en=0 keeps the scanner idle.
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(dataOut), 32'd0);
    check("rst_ch", 32'(chOut), 32'd0);
    rst = 1'b0; chMask = 4'b1111;
    repeat (10) @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_sel", 32'(sel), 32'd0);

    // 2: full mask, ready high -> channels 0,1,2,3,0.
    ready = 1'b1; en = 1'b1;
    chs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    dats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h00, 8'h00, 8'h00};
    expect_seq("rr4", 5, chs, dats);

    // 3: mask 1010 alternates channels 1 and 3; empty mask -> idle.
    chMask = 4'b1010;
    chs  = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    dats = '{8'h22, 8'h44, 8'h22, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_seq("alt", 4, chs, dats);
    chMask = 4'b0000;
    repeat (12) @(negedge clk);
    check("mask0_valid", 32'(valid), 32'd0);
    check("mask0_sel", 32'(sel), 32'd3);

    // 4: backpressure freezes the held sample while muxIn moves.
    ready = 1'b0; chMask = 4'b1111;
    wait_valid("bp");
    check("bp_first_data", 32'(dataOut), 32'h11);
    for (int i = 0; i < 10; i++) begin
      chan_val[0] = 8'(i * 7 + 3);
      @(negedge clk);
      check("bp_data", 32'(dataOut), 32'h11);
      check("bp_ch", 32'(chOut), 32'd0);
      check("bp_sel", 32'(sel), 32'd0);
      check("bp_valid", 32'(valid), 32'd1);
    end
    chan_val[0] = 8'h11;
    ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(valid), 32'd0);
    ready = 1'b0;

    // 5: reset while settling on channel 1 (cnt=2), then restart at channel 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_data", 32'(dataOut), 32'd0);
    check("midrst_ch", 32'(chOut), 32'd0);
    rst = 1'b0;
    wait_valid("restart");
    check("restart_ch", 32'(chOut), 32'd0);
    check("restart_data", 32'(dataOut), 32'h11);
    ready = 1'b1;

    // Single enabled channel is rescanned with sel held constant.
    chMask = 4'b0100;
    chs  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    dats = '{8'h33, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_seq("single", 3, chs, dats);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("single_idle_valid", 32'(valid), 32'd0);

`ifdef MUX_SCAN_CHANGE_EN
    // 6: repeated identical values are presented only once.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; chMask = 4'b0001; chan_val[0] = 8'h5A; en = 1'b1; ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nv++;
        check("chg_data", 32'(dataOut), 32'h5A);
      end
    end
    check("chg_one_valid", 32'(nv), 32'd1);
    chan_val[0] = 8'h5B;
    wait_valid("chg_second");
    check("chg_second_data", 32'(dataOut), 32'h5B);
    en = 1'b0;
    repeat (3) @(negedge clk);
`else
    nv = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
